// File: rtl/i2c_sensor_target.sv
// rtl/i2c_sensor_target.sv - I2C target emulating one 16-bit sensor register (optional macro: I2C_TARGET_GLITCH_FILTER_EN)
module i2c_sensor_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h44,
  parameter logic [7:0]  REG_ADDR  = 8'h00,
  parameter logic [15:0] MISS_DATA = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] sensor_value,
  output logic [7:0]  reg_ptr,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WACK, S_WDATA, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_c, sda_c;
  logic        scl_prev_q, sda_prev_q;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  reg_ptr_q, reg_ptr_d;
  logic [15:0] snap_q, snap_d;
  logic        sda_low_q, sda_low_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        byte_sel_q, byte_sel_d;
  logic        mack_q, mack_d;

  // Two-flop synchronizers on the bus lines, idle-high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // 3-tap majority vote drops single-cycle pulses after synchronization
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
      scl_filt_q <= (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                    (scl_hist_q[1] & scl_hist_q[2]);
      sda_filt_q <= (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                    (sda_hist_q[1] & sda_hist_q[2]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  wire scl_rise = scl_c & ~scl_prev_q;
  wire scl_fall = ~scl_c & scl_prev_q;
  wire start_c  = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
  wire stop_c   = scl_c & scl_prev_q & sda_c & ~sda_prev_q;

  wire [7:0] in_byte = {shift_q[6:0], sda_c};
  wire [7:0] tx_byte = byte_sel_q ? snap_q[7:0] : snap_q[15:8];
  wire [2:0] bit_idx = 3'd7 - bit_cnt_q[2:0];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      reg_ptr_q  <= '0;
      snap_q     <= '0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_done_q  <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      byte_sel_q <= 1'b0;
      mack_q     <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_ptr_q  <= reg_ptr_d;
      snap_q     <= snap_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      rd_done_q  <= rd_done_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      byte_sel_q <= byte_sel_d;
      mack_q     <= mack_d;
    end
  end

  // Bus protocol: START/STOP override everything, otherwise per-state bit handling
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_ptr_d  = reg_ptr_q;
    snap_d     = snap_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    rd_done_d  = 1'b0;
    rw_d       = rw_q;
    phase_d    = phase_q;
    byte_sel_d = byte_sel_q;
    mack_d     = mack_q;

    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else if (stop_c) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (in_byte[7:1] == DEV_ADDR) begin
              state_d = S_ADDR_ACK;
              phase_d = 1'b0;
              rw_d    = in_byte[0];
              busy_d  = 1'b1;
              snap_d  = (reg_ptr_q == REG_ADDR) ? sensor_value : MISS_DATA;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_low_d = 1'b1;
            phase_d   = 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d    = S_TX;
              byte_sel_d = 1'b0;
              sda_low_d  = ~snap_q[15];
            end else begin
              state_d   = S_PTR;
              sda_low_d = 1'b0;
            end
          end
        end
        S_PTR, S_WDATA: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = S_WACK;
            phase_d = 1'b0;
            if (state_q == S_PTR) reg_ptr_d = in_byte;
          end
        end
        S_WACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_low_d = 1'b1;
            phase_d   = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            state_d   = S_WDATA;
            bit_cnt_d = '0;
          end
        end
        S_TX: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              state_d   = S_TX_ACK;
            end else begin
              sda_low_d = ~tx_byte[bit_idx];
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) mack_d = sda_c;
          if (scl_fall) begin
            if (byte_sel_q) rd_done_d = 1'b1;
            if (!mack_q) begin
              byte_sel_d = ~byte_sel_q;
              sda_low_d  = byte_sel_q ? ~snap_q[15] : ~snap_q[7];
              state_d    = S_TX;
              bit_cnt_d  = '0;
            end else begin
              sda_low_d = 1'b0;
              state_d   = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda     = sda_low_q ? 1'b0 : 1'bz;
  assign reg_ptr = reg_ptr_q;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// tb/tb_i2c_sensor_target.sv - scoreboard testbench for i2c_sensor_target
`timescale 1ns/1ps
module tb_i2c_sensor_target;
  localparam time TQ = 50ns;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [15:0] sensor_value = '0;
  wire         sda_w;
  logic [7:0]  reg_ptr;
  logic        busy;
  logic        rd_done;

  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_sensor_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_w),
    .sensor_value(sensor_value), .reg_ptr(reg_ptr), .busy(busy), .rd_done(rd_done)
  );

  typedef struct { string tag; logic [15:0] val; } item_t;
  item_t exp_q[$];
  item_t obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int busy_cyc = 0;
  int rd_cnt   = 0;
  logic [7:0] ptr_m = 8'h00;

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (rd_done) rd_cnt++;
  end

  function automatic void expect_item(string t, logic [15:0] v);
    item_t it;
    it.tag = t; it.val = v;
    exp_q.push_back(it);
  endfunction

  function automatic void observe(string t, logic [15:0] v);
    item_t it;
    it.tag = t; it.val = v;
    obs_q.push_back(it);
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        item_t o, e;
        o = obs_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s: got %h with no expected value queued", o.tag, o.val);
        end else begin
          e = exp_q.pop_front();
          if (e.tag == o.tag && e.val == o.val) n_pass++;
          else $display("FAIL %s: got %h (%s) expected %h", e.tag, o.val, o.tag, e.val);
        end
      end
    end
  end

  task automatic clock_bit(input logic b, output logic r);
    m_sda_low = ~b; #TQ;
    scl = 1'b1;     #TQ;
    r = sda_w;      #TQ;
    scl = 1'b0;     #TQ;
  endtask

  task automatic start_c();
    m_sda_low = 1'b0; #TQ;
    scl = 1'b1;       #TQ;
    m_sda_low = 1'b1; #TQ;
    scl = 1'b0;       #TQ;
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1; #TQ;
    scl = 1'b1;       #TQ;
    m_sda_low = 1'b0; #TQ;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
    clock_bit(nack, r);
  endtask

  // One master transaction; expectations come from the register/pointer model
  task automatic do_txn(input logic [6:0] addr, input bit wr_ptr, input logic [7:0] p,
                        input int nread, input logic [15:0] v, input logic [15:0] v2);
    logic ack;
    logic [7:0] d;
    logic [15:0] snap;
    int b0, r0;
    bit hit;
    hit = (addr == 7'h44);
    b0 = busy_cyc; r0 = rd_cnt;
    sensor_value = v;
    start_c();
    if (wr_ptr || !hit) begin
      write_byte({addr, 1'b0}, ack);
      observe("ack_addr_w", 16'(ack)); expect_item("ack_addr_w", hit ? 16'd0 : 16'd1);
      if (!hit) begin
        stop_c();
        repeat (10) @(posedge clk);
        observe("busy_cycles_miss", 16'(busy_cyc - b0)); expect_item("busy_cycles_miss", 16'd0);
        return;
      end
      write_byte(p, ack);
      observe("ack_ptr", 16'(ack)); expect_item("ack_ptr", 16'd0);
      ptr_m = p;
      start_c();
    end
    snap = (ptr_m == 8'h00) ? v : 16'h0000;
    write_byte({addr, 1'b1}, ack);
    observe("ack_addr_r", 16'(ack)); expect_item("ack_addr_r", 16'd0);
    for (int i = 0; i < nread; i++) begin
      read_byte(i == nread - 1, d);
      observe("rd_byte", 16'(d)); expect_item("rd_byte", (i % 2 == 0) ? 16'(snap[15:8]) : 16'(snap[7:0]));
      if (i == 0) sensor_value = v2;
    end
    stop_c();
    repeat (10) @(posedge clk);
    observe("rd_done_pulses", 16'(rd_cnt - r0)); expect_item("rd_done_pulses", 16'(nread / 2));
    observe("reg_ptr", 16'(reg_ptr)); expect_item("reg_ptr", 16'(ptr_m));
    observe("busy_after_stop", 16'(busy)); expect_item("busy_after_stop", 16'd0);
    observe("busy_seen", 16'(busy_cyc > b0)); expect_item("busy_seen", 16'd1);
  endtask

  initial begin : stimulus
    logic ack, r;
    logic [7:0] d;
    int b0, r0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    observe("rst_reg_ptr", 16'(reg_ptr)); expect_item("rst_reg_ptr", 16'h00);
    observe("rst_busy", 16'(busy));       expect_item("rst_busy", 16'd0);
    observe("rst_rd_done", 16'(rd_done)); expect_item("rst_rd_done", 16'd0);
    observe("rst_sda", 16'(sda_w));       expect_item("rst_sda", 16'd1);
    repeat (5) @(posedge clk);

    do_txn(7'h44, 1'b1, 8'h00, 2, 16'hABCD, 16'hABCD);
    do_txn(7'h45, 1'b1, 8'h00, 2, 16'h1111, 16'h1111);
    do_txn(7'h44, 1'b1, 8'h00, 2, 16'h2468, 16'h2468);
    do_txn(7'h44, 1'b1, 8'h02, 2, 16'hBEEF, 16'hBEEF);
    do_txn(7'h44, 1'b1, 8'h00, 2, 16'h1234, 16'h5678);
    do_txn(7'h44, 1'b0, 8'h00, 3, 16'hC3A5, 16'h0F0F);

    for (int k = 0; k < 12; k++) begin
      logic [6:0] a;
      a = 7'h44;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h44) a = 7'h45;
      end
      do_txn(a, $urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom),
             $urandom_range(1, 3), 16'($urandom), 16'($urandom));
    end

    // STOP in the middle of the MSB
    sensor_value = 16'hABCD;
    b0 = busy_cyc; r0 = rd_cnt;
    start_c();
    write_byte(8'h88, ack);
    observe("abort_ack_w", 16'(ack)); expect_item("abort_ack_w", 16'd0);
    write_byte(8'h00, ack);
    ptr_m = 8'h00;
    start_c();
    write_byte(8'h89, ack);
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, r);
      observe("abort_bit", 16'(r)); expect_item("abort_bit", (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    stop_c();
    repeat (10) @(posedge clk);
    observe("abort_busy", 16'(busy)); expect_item("abort_busy", 16'd0);
    observe("abort_rd_done", 16'(rd_cnt - r0)); expect_item("abort_rd_done", 16'd0);

    // Reset while the target holds the address ACK low
    start_c();
    write_byte(8'h88, ack);
    write_byte(8'h5A, ack);
    ptr_m = 8'h5A;
    start_c();
    for (int i = 7; i >= 0; i--) clock_bit(d[0] | (8'h88 >> i) & 8'h01, r);
    m_sda_low = 1'b0; #TQ;
    scl = 1'b1;       #TQ;
    observe("ack_before_rst", 16'(sda_w)); expect_item("ack_before_rst", 16'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    observe("rst_sda_release", 16'(sda_w)); expect_item("rst_sda_release", 16'd1);
    observe("rst_busy_mid", 16'(busy));      expect_item("rst_busy_mid", 16'd0);
    observe("rst_reg_ptr_mid", 16'(reg_ptr)); expect_item("rst_reg_ptr_mid", 16'h00);
    ptr_m = 8'h00;
    @(negedge clk) rst = 1'b0;
    scl = 1'b0; #TQ;
    stop_c();
    repeat (10) @(posedge clk);

    do_txn(7'h44, 1'b0, 8'h00, 2, 16'h7E81, 16'h7E81);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // A one-clock low pulse on scl during TX must not advance the bit counter
    sensor_value = 16'h96C3;
    start_c();
    write_byte(8'h89, ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = 1'b0; #TQ;
      scl = 1'b1; #20ns;
      if (i == 4) begin
        @(negedge clk) scl = 1'b0;
        @(negedge clk) scl = 1'b1;
      end
      #(TQ - 20ns);
      d[i] = sda_w; #TQ;
      scl = 1'b0; #TQ;
    end
    clock_bit(1'b1, r);
    observe("glitch_msb", 16'(d)); expect_item("glitch_msb", 16'h96);
    stop_c();
    repeat (10) @(posedge clk);
`endif

    for (int t = 0; t < 100 && obs_q.size() > 0; t++) @(posedge clk);
    @(negedge clk); @(negedge clk);
    while (exp_q.size() > 0) begin
      item_t e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL %s: got no observation expected %h", e.tag, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
